// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter: FSM states, grant IDs and access size codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// One request/response channel (requester <-> arbiter or arbiter <-> cpu_axi_interface).
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              addr_ok;
    logic              data_ok;

    // master issues requests, slave answers them
    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/arb_pick.sv
// Chooses the winner between instruction and data requests.
// ARB_ROUND_ROBIN_EN: ties alternate against the last grant; otherwise data has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_inst_req,
    input  logic   i_data_req,
    input  grant_e i_last_gnt,
    output grant_e o_gnt
);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        o_gnt = GNT_DATA;
        if (i_inst_req && !i_data_req) begin
            o_gnt = GNT_INST;
        end else if (i_inst_req && i_data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i_last_gnt == GNT_DATA) begin
                o_gnt = GNT_INST;
            end else begin
                o_gnt = GNT_DATA;
            end
`else
            o_gnt = GNT_DATA;
`endif
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-to-one arbiter funnelling instruction and data requests into one downstream port,
// one transaction outstanding. ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_req_arbiter_if.slave         inst_if,
    mem_req_arbiter_if.slave         data_if,
    mem_req_arbiter_if.master        mem_if
);

    state_e            r_state;
    state_e            w_next_state;
    grant_e            r_gnt;
    grant_e            w_pick;
    grant_e            w_last_gnt;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_latch;
    logic              w_addr_ok;
    logic              w_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e r_last_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= GNT_DATA;
        end else if (w_latch) begin
            r_last_gnt <= w_pick;
        end
    end

    assign w_last_gnt = r_last_gnt;
`else
    assign w_last_gnt = GNT_DATA;
`endif

    arb_pick u_pick (
        .i_inst_req (inst_if.req),
        .i_data_req (data_if.req),
        .i_last_gnt (w_last_gnt),
        .o_gnt      (w_pick)
    );

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;
        case (r_state)
            IDLE: begin
                if (inst_if.req || data_if.req) begin
                    w_latch      = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (mem_if.addr_ok) begin
                    w_addr_ok = 1'b1;
                    if (mem_if.data_ok) begin
                        w_data_ok    = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_if.data_ok) begin
                    w_data_ok    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= GNT_DATA;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_gnt <= w_pick;
                if (w_pick == GNT_INST) begin
                    r_wr    <= inst_if.wr;
                    r_size  <= inst_if.size;
                    r_addr  <= inst_if.addr;
                    r_wdata <= inst_if.wdata;
                end else begin
                    r_wr    <= data_if.wr;
                    r_size  <= data_if.size;
                    r_addr  <= data_if.addr;
                    r_wdata <= data_if.wdata;
                end
            end
        end
    end

    // Outputs are forced quiet while rst is high so an abandoned transaction never completes.
    assign mem_if.req   = !rst && (r_state == REQ);
    assign mem_if.wr    = !rst && r_wr;
    assign mem_if.size  = rst ? '0 : r_size;
    assign mem_if.addr  = rst ? '0 : r_addr;
    assign mem_if.wdata = rst ? '0 : r_wdata;

    assign inst_if.addr_ok = !rst && w_addr_ok && (r_gnt == GNT_INST);
    assign inst_if.data_ok = !rst && w_data_ok && (r_gnt == GNT_INST);
    assign data_if.addr_ok = !rst && w_addr_ok && (r_gnt == GNT_DATA);
    assign data_if.data_ok = !rst && w_data_ok && (r_gnt == GNT_DATA);

    assign inst_if.rdata = mem_if.rdata;
    assign data_if.rdata = mem_if.rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_req_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          wr;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   m_last_data = 1'b1;

    mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
    mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
    mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .inst_if (inst_if),
        .data_if (data_if),
        .mem_if  (mem_if)
    );

    always #5 clk = ~clk;

    // Model: 1 means the data side wins.
    function automatic bit pick_model(bit ireq, bit dreq, bit last_data);
        if (ireq && !dreq) return 1'b0;
        if (dreq && !ireq) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_data;
`else
        return 1'b1 | last_data;
`endif
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.wr    = 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.addr  = $urandom;
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic logic [3:0] oks();
        return {inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok};
    endfunction

    function automatic logic [67:0] mem_bus();
        return {mem_if.req, mem_if.wr, mem_if.size, mem_if.addr, mem_if.wdata};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_inst(logic req, req_t r);
        inst_if.req = req; inst_if.wr = r.wr; inst_if.size = r.size;
        inst_if.addr = r.addr; inst_if.wdata = r.wdata;
    endtask

    task automatic set_data(logic req, req_t r);
        data_if.req = req; data_if.wr = r.wr; data_if.size = r.size;
        data_if.addr = r.addr; data_if.wdata = r.wdata;
    endtask

    task automatic test_reset();
        req_t z = '{1'b0, 2'd0, '0, '0};
        rst = 1'b1;
        set_inst(1'b0, z);
        set_data(1'b0, z);
        mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = '0;
        m_last_data = 1'b1;
        repeat (2) cycle();
        sample();
        checks++; if (mem_bus() !== 68'd0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", mem_bus()); end
        checks++; if (oks() !== 4'b0000) begin errors++; $display("FAIL reset_oks: got %b want 0000", oks()); end
        cycle();
        rst = 1'b0;
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'hA5A5_1234;
        sample();
        checks++; if (mem_bus() !== 68'd0) begin errors++; $display("FAIL post_reset_mem_bus: got %h want 0", mem_bus()); end
        checks++; if (oks() !== 4'b0000) begin errors++; $display("FAIL post_reset_oks: got %b want 0000", oks()); end
        checks++; if (inst_if.rdata !== 32'hA5A5_1234 || data_if.rdata !== 32'hA5A5_1234) begin
            errors++; $display("FAIL rdata_passthru: got %h/%h want a5a51234", inst_if.rdata, data_if.rdata); end
    endtask

    task automatic test_inst_read();
        cycle();
        set_inst(1'b1, '{1'b0, 2'd2, 32'hBFC0_0000, 32'h0});
        sample();
        checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL ird_c0_req: got %b want 0", mem_if.req); end
        cycle();
        m_last_data = 1'b0;
        sample();
        checks++; if (mem_bus() !== {1'b1, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0}) begin
            errors++; $display("FAIL ird_c1_bus: got %h", mem_bus()); end
        checks++; if (oks() !== 4'b0000) begin errors++; $display("FAIL ird_c1_oks: got %b want 0000", oks()); end
        cycle();
        mem_if.addr_ok = 1'b1;
        sample();
        checks++; if (oks() !== 4'b1000) begin errors++; $display("FAIL ird_c2_oks: got %b want 1000", oks()); end
        cycle();
        mem_if.addr_ok = 1'b0;
        inst_if.req = 1'b0;
        sample();
        checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL ird_c3_quiet: got %b want 00000", {mem_if.req, oks()}); end
        cycle();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3C08_0001;
        sample();
        checks++; if (oks() !== 4'b0100) begin errors++; $display("FAIL ird_c4_oks: got %b want 0100", oks()); end
        checks++; if (inst_if.rdata !== 32'h3C08_0001) begin errors++; $display("FAIL ird_c4_rdata: got %h want 3c080001", inst_if.rdata); end
        cycle();
        mem_if.data_ok = 1'b0;
        sample();
        checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL ird_c5_idle: got %b want 00000", {mem_if.req, oks()}); end
    endtask

    task automatic test_tie();
        req_t ri = '{1'b0, 2'd2, 32'h1000_0004, 32'h0};
        req_t rd = '{1'b1, 2'd1, 32'h2000_0008, 32'h1234_5678};
        for (int round = 0; round < 2; round++) begin
            bit first_d = pick_model(1'b1, 1'b1, m_last_data);
            cycle();
            set_inst(1'b1, ri);
            set_data(1'b1, rd);
            sample();
            checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL tie_idle_req r%0d: got %b want 0", round, mem_if.req); end
            for (int k = 0; k < 2; k++) begin
                bit wd = (k == 0) ? first_d : !first_d;
                req_t w = wd ? rd : ri;
                m_last_data = wd;
                cycle();
                sample();
                checks++; if (mem_bus() !== {1'b1, w.wr, w.size, w.addr, w.wdata}) begin
                    errors++; $display("FAIL tie_bus r%0d k%0d: got %h want side %s", round, k, mem_bus(), wd ? "data" : "inst"); end
                cycle();
                mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
                sample();
                checks++; if (oks() !== (wd ? 4'b0011 : 4'b1100)) begin
                    errors++; $display("FAIL tie_oks r%0d k%0d: got %b want %b", round, k, oks(), wd ? 4'b0011 : 4'b1100); end
                cycle();
                mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0;
                if (wd) data_if.req = 1'b0; else inst_if.req = 1'b0;
                sample();
                checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL tie_after r%0d k%0d: got %b want 00000", round, k, {mem_if.req, oks()}); end
            end
        end
    endtask

    task automatic test_write_stall();
        logic [67:0] exp_bus = {1'b1, 1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF};
        cycle();
        set_data(1'b1, '{1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF});
        m_last_data = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            data_if.addr = $urandom; data_if.wdata = $urandom; data_if.size = 2'd0;
            mem_if.data_ok = (k == 1);
            sample();
            checks++; if (mem_bus() !== exp_bus) begin errors++; $display("FAIL wr_stall_bus k%0d: got %h want %h", k, mem_bus(), exp_bus); end
            checks++; if (oks() !== 4'b0000) begin errors++; $display("FAIL wr_stall_oks k%0d: got %b want 0000", k, oks()); end
        end
        cycle();
        mem_if.data_ok = 1'b0; mem_if.addr_ok = 1'b1;
        sample();
        checks++; if (oks() !== 4'b0010) begin errors++; $display("FAIL wr_addr_ok: got %b want 0010", oks()); end
        cycle();
        mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; data_if.req = 1'b0;
        sample();
        checks++; if (oks() !== 4'b0001) begin errors++; $display("FAIL wr_data_ok: got %b want 0001", oks()); end
        cycle();
        mem_if.data_ok = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        cycle();
        set_data(1'b1, '{1'b0, 2'd0, 32'h0000_0040, 32'h0});
        cycle();
        mem_if.addr_ok = 1'b1;
        sample();
        checks++; if (oks() !== 4'b0010) begin errors++; $display("FAIL rstw_addr_ok: got %b want 0010", oks()); end
        cycle();
        mem_if.addr_ok = 1'b0; data_if.req = 1'b0;
        rst = 1'b1; mem_if.data_ok = 1'b1;
        m_last_data = 1'b1;
        sample();
        checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL rstw_during: got %b want 00000", {mem_if.req, oks()}); end
        cycle();
        rst = 1'b0;
        sample();
        checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL rstw_late_data_ok: got %b want 00000", {mem_if.req, oks()}); end
        cycle();
        sample();
        checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL rstw_idle: got %b want 00000", {mem_if.req, oks()}); end
        cycle();
        mem_if.data_ok = 1'b0;
    endtask

    task automatic test_random();
        bit   pend_i = 1'b0, pend_d = 1'b0;
        req_t ri = rand_req(), rd = rand_req();
        for (int t = 0; t < 80; t++) begin
            bit   wd, both;
            req_t w;
            logic [DW-1:0] rv;
            if (!pend_i && $urandom_range(0, 1) == 1) begin pend_i = 1'b1; ri = rand_req(); end
            if (!pend_d && $urandom_range(0, 1) == 1) begin pend_d = 1'b1; rd = rand_req(); end
            set_inst(pend_i, ri);
            set_data(pend_d, rd);
            mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'($urandom_range(0, 1));
            sample();
            checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL rnd_idle t%0d: got %b want 00000", t, {mem_if.req, oks()}); end
            cycle();
            if (!pend_i && !pend_d) continue;
            wd = pick_model(pend_i, pend_d, m_last_data);
            m_last_data = wd;
            w = wd ? rd : ri;
            repeat ($urandom_range(0, 3)) begin
                mem_if.data_ok = 1'($urandom_range(0, 1));
                sample();
                checks++; if (mem_bus() !== {1'b1, w.wr, w.size, w.addr, w.wdata} || oks() !== 4'b0000) begin
                    errors++; $display("FAIL rnd_stall t%0d: got %h oks %b want side %s", t, mem_bus(), oks(), wd ? "data" : "inst"); end
                cycle();
            end
            both = 1'($urandom_range(0, 1));
            rv = $urandom;
            mem_if.addr_ok = 1'b1; mem_if.data_ok = both; mem_if.rdata = rv;
            sample();
            checks++; if (mem_bus() !== {1'b1, w.wr, w.size, w.addr, w.wdata}) begin
                errors++; $display("FAIL rnd_bus t%0d: got %h want side %s", t, mem_bus(), wd ? "data" : "inst"); end
            checks++; if (oks() !== (wd ? {2'b00, 1'b1, both} : {1'b1, both, 2'b00})) begin
                errors++; $display("FAIL rnd_addr_oks t%0d: got %b winner %s both %b", t, oks(), wd ? "data" : "inst", both); end
            cycle();
            mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0;
            if (wd) begin pend_d = 1'b0; data_if.req = 1'b0; end
            else begin pend_i = 1'b0; inst_if.req = 1'b0; end
            if (!both) begin
                repeat ($urandom_range(0, 3)) begin
                    sample();
                    checks++; if ({mem_if.req, oks()} !== 5'b0) begin errors++; $display("FAIL rnd_wait t%0d: got %b want 00000", t, {mem_if.req, oks()}); end
                    cycle();
                end
                mem_if.data_ok = 1'b1;
                sample();
                checks++; if (oks() !== (wd ? 4'b0001 : 4'b0100)) begin
                    errors++; $display("FAIL rnd_data_oks t%0d: got %b want %b", t, oks(), wd ? 4'b0001 : 4'b0100); end
                checks++; if ((wd ? data_if.rdata : inst_if.rdata) !== rv) begin
                    errors++; $display("FAIL rnd_rdata t%0d: got %h want %h", t, wd ? data_if.rdata : inst_if.rdata, rv); end
                cycle();
                mem_if.data_ok = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_inst_read();
        test_tie();
        test_write_stall();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of every address port.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of every wdata and rdata port.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 inst_req/inst_wr  input  1/1  SHALL be the instruction-side request and write flag.
REQ-006 inst_size  input  2  SHALL give the instruction-side access size (0=byte, 1=half, 2=word).
REQ-007 inst_addr/inst_wdata  input  ADDR_W/DATA_W  SHALL be the instruction-side address and write data.
REQ-008 inst_rdata/inst_addr_ok/inst_data_ok  output  DATA_W/1/1  SHALL be the instruction-side read data, address accept and data done.
REQ-009 data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok SHALL mirror REQ-005..008 for the data side.
REQ-010 mem_req, mem_wr, mem_size, mem_addr, mem_wdata  output SHALL form the single shared downstream request to cpu_axi_interface.
REQ-011 mem_rdata/mem_addr_ok/mem_data_ok  input  DATA_W/1/1  SHALL be the downstream response.

Function
REQ-012 States SHALL be IDLE, REQ and WAIT; at most one transaction outstanding.
REQ-013 IDLE: if any requester has req=1, the arbiter SHALL latch the grant (INST or DATA) plus the winner's wr/size/addr/wdata and go to REQ on the next edge.
REQ-014 IDLE latency: the request seen at edge N SHALL assert mem_req in cycle N+1.
REQ-015 REQ: mem_req=1 and mem_wr/size/addr/wdata SHALL be driven from the latched copies, stable until mem_addr_ok.
REQ-016 REQ with mem_addr_ok=1: the granted side's addr_ok SHALL pulse for one cycle and the arbiter SHALL go to WAIT.
REQ-017 If mem_data_ok=1 in the same cycle as mem_addr_ok, the granted side's data_ok SHALL pulse too and the next state SHALL be IDLE.
REQ-018 WAIT with mem_data_ok=1: the granted side's data_ok SHALL pulse for one cycle and the arbiter SHALL return to IDLE; WAIT otherwise holds.
REQ-019 inst_rdata and data_rdata SHALL both carry mem_rdata combinationally; only data_ok qualifies them.
REQ-020 The non-granted side's addr_ok and data_ok SHALL be 0 at all times.
REQ-021 The arbiter SHALL ignore mem_data_ok in IDLE and REQ, except as allowed in REQ-017.
REQ-022 Simultaneous inst_req and data_req in IDLE SHALL be resolved per REQ-027/028; the loser keeps req high and SHALL be served next.

Reset
REQ-023 While rst=1: state IDLE, grant DATA, latched fields 0, round-robin pointer DATA.
REQ-024 Outputs during and after reset: mem_req 0, all addr_ok/data_ok 0, mem_wr 0, mem_size 0, mem_addr 0, mem_wdata 0.
REQ-025 Reset asserted in REQ or WAIT SHALL abandon the transaction with no data_ok pulse.

Configuration
REQ-026 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-027 Defined: on a tie the side not granted last time SHALL win; the pointer SHALL update only on a grant.
REQ-028 Undefined: fixed priority; data wins every tie and no pointer register exists.

Structure
REQ-029 The shared package mem_arb_pkg SHALL hold the state enum, the grant IDs (GNT_INST, GNT_DATA) and the size encodings.
REQ-030 The pick logic SHALL be a sub-module, arb_pick (two req inputs, last-grant input, grant output); it contains the ARB_ROUND_ROBIN_EN choice.

Verification
REQ-031 Inst read 0xBFC00000, mem_addr_ok at cycle 2, mem_data_ok at cycle 4 with 0x3C080001 -> inst_addr_ok at cycle 2, inst_data_ok with rdata 0x3C080001 at cycle 4, data side silent.
REQ-032 Both req in the same cycle, without macro -> data first, then inst; with macro on the second tie -> inst wins.
REQ-033 Data word write 0x80001000 = 0xDEADBEEF with mem_addr_ok held low for 3 cycles -> mem_addr, mem_wdata, mem_size=2 and mem_wr=1 stable for all 3 cycles.
REQ-034 mem_addr_ok and mem_data_ok in the same cycle -> addr_ok and data_ok pulse together, IDLE next cycle.
REQ-035 rst raised in WAIT -> IDLE next cycle, no data_ok, and a later mem_data_ok is ignored.
REQ-036 mem_data_ok pulsed in IDLE -> no data_ok on either side.
